hamming_dist_avs: RTL and testbench
===================================

Name: hamming_dist_avs

Overview:
Avalon-MM slave Hamming-distance engine on the FPGA fabric, directly downstream of the HPS lightweight bridge in soc_hamming_hps. The host sets a word count, starts a job, then streams operand word pairs (A, B). The block XORs each pair, popcounts the result and accumulates a saturating total. Status also drives the three FPGA LEDs.

Parameters:
DATA_W, 32, operand word width (only 32 is supported)
ACC_W, 32, width of the accumulated distance register
LEN_W, 16, width of the word-count register

Ports:
clk  in  1  fabric clock (100 MHz)
reset_n  in  1  asynchronous active-low reset
avs_address  in  3  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, fixed read latency 1
led_status  out  3  bit0=busy, bit1=done, bit2=overflow
irq  out  1  present only with HAMMING_IRQ_EN

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: all registers 0, state IDLE, avs_readdata=0, led_status=0, irq=0.
- Register map (read returns 0 in unused bits):
  - 0 CTRL (W): bit0 start, bit1 clear. Both are self-clearing pulses; reads return 0.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 overflow, bits[31:16] words remaining.
  - 2 LEN (RW): job length in word pairs, LEN_W bits.
  - 3 DATA_A (W): latched operand A.
  - 4 DATA_B (W): writing B consumes the pair {A_reg, writedata}.
  - 5 RESULT (R): accumulator, zero-extended.
  - 6 IRQ_EN (RW): bit0; only with the macro, otherwise reads 0.
- Reads: avs_readdata is registered and valid the cycle after avs_read. Writes complete in one cycle. There is no waitrequest.
- FSM states:
  - IDLE -> ACCUM on a start write. The start write clears the accumulator, overflow and done, and loads remaining=LEN.
  - ACCUM -> DRAIN when a DATA_B write makes remaining reach 0.
  - DRAIN -> DONE once the pipeline is empty (2 cycles).
  - DONE -> ACCUM on start; DONE -> IDLE on clear.
  - Clear from any state -> IDLE and zeroes accumulator, remaining, done and overflow; any pipeline contents are discarded.
- Start with LEN=0: transition to DRAIN, then DONE, with result 0.
- Pipeline, 3 stages:
  - S0: register A^B.
  - S1: popcount (0..32, 6 bits).
  - S2: accumulator += count.
  - RESULT is updated 3 cycles after the DATA_B write. Back-to-back DATA_B writes every cycle are sustained.
- Saturation: if acc+count exceeds 2^ACC_W-1, the accumulator holds all-ones and overflow is set (sticky until the next start or clear).
- Ignored or idempotent accesses:
  - DATA_B writes outside ACCUM are ignored; no state change.
  - DATA_A writes are accepted in any state.
  - Start while in ACCUM or DRAIN is ignored.
  - LEN writes while busy are stored but do not affect the running job.
- Simultaneous start and clear in the same write: clear wins.
- Asynchronous reset mid-job: immediate return to reset values; no partial result is retained.
- busy = state is ACCUM or DRAIN. done = state is DONE.

Optional Feature:
- HAMMING_IRQ_EN defined:
  - Adds the irq output and the IRQ_EN register.
  - irq rises on the DRAIN->DONE transition when IRQ_EN[0]=1 and stays level-high until a start or clear.
- Undefined: no irq port and no IRQ_EN register; address 6 reads 0 and writes are ignored.

Decomposition:
- Package hamming_pkg:
  - register address constants (REG_CTRL..REG_IRQ_EN)
  - CTRL/STATUS bit index constants
  - FSM state enum (IDLE, ACCUM, DRAIN, DONE)
  - popcount result width constant (6)
- Sub-module hamming_popcount32: combinational 32-bit popcount tree, instantiated in S1.

Test Plan:
- Reset, then read STATUS and RESULT -> both 0; led_status=000.
- LEN=1, start, A=0xFFFF0000, B=0x0000FFFF -> RESULT=32 and STATUS=0x0000_0002 on the first read issued ≥4 cycles after the B write.
- LEN=4, start, B writes on 4 consecutive cycles with A=0, B=0x1,0x3,0x7,0xF -> RESULT=10, done=1, remaining=0.
- ACC_W=6, LEN=3, three pairs with XOR=0xFFFFFFFF -> RESULT=63, overflow=1, led_status=110.
- Mid-job (LEN=5, two pairs sent): write CTRL=0x3 -> state IDLE, RESULT=0, busy=0; a subsequent B write leaves RESULT unchanged.
- With HAMMING_IRQ_EN, IRQ_EN=1, LEN=0, start -> irq=1 within 3 cycles; start again -> irq=0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming-distance engine.
package hamming_pkg;

  // Register word addresses
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_DATA_A = 3'd3;
  localparam logic [2:0] REG_DATA_B = 3'd4;
  localparam logic [2:0] REG_RESULT = 3'd5;
  localparam logic [2:0] REG_IRQ_EN = 3'd6;

  // CTRL bit positions
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_OVF_BIT  = 2;
  localparam int unsigned STAT_REM_LSB  = 16;
  localparam int unsigned STAT_REM_W    = 16;

  // Popcount of a 32-bit word spans 0..32
  localparam int unsigned POPCNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/hamming_popcount32.sv
// Combinational 32-bit popcount: eight nibble counts summed in a small tree.
module hamming_popcount32
  import hamming_pkg::*;
(
  input  logic [31:0]         data,
  output logic [POPCNT_W-1:0] count_c
);

  logic [2:0] nib_c [8];
  logic [3:0] pair_c [4];
  logic [4:0] quad_c [2];

  // Per-nibble counts, then pairwise reduction
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      nib_c[k] = 3'(data[4*k]) + 3'(data[4*k+1]) + 3'(data[4*k+2]) + 3'(data[4*k+3]);
    end
    for (int k = 0; k < 4; k++) begin
      pair_c[k] = 4'(nib_c[2*k]) + 4'(nib_c[2*k+1]);
    end
    for (int k = 0; k < 2; k++) begin
      quad_c[k] = 5'(pair_c[2*k]) + 5'(pair_c[2*k+1]);
    end
    count_c = POPCNT_W'(quad_c[0]) + POPCNT_W'(quad_c[1]);
  end

endmodule

// File: rtl/hamming_dist_avs.sv
// Avalon-MM Hamming-distance accumulator: XOR -> popcount -> saturating sum.
// Optional macro HAMMING_IRQ_EN adds the irq output and IRQ_EN register.
module hamming_dist_avs
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
`ifdef HAMMING_IRQ_EN
  output logic              irq,
`endif
  output logic [2:0]        led_status
);

  state_t              state;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    remaining;
  logic [DATA_W-1:0]   a_reg;
  logic [ACC_W-1:0]    acc;
  logic                overflow;
  logic                s0_valid;
  logic [DATA_W-1:0]   s0_xor;
  logic                s1_valid;
  logic [POPCNT_W-1:0] s1_cnt;
  logic [POPCNT_W-1:0] pop_c;
  logic [ACC_W:0]      sum_c;
  logic                wr_ctrl_c;
  logic                start_c;
  logic                clear_c;
  logic                wr_b_c;
  logic                busy_c;
  logic                done_c;
  logic                drain_exit_c;
  logic                start_ok_c;
  logic [31:0]         rd_mux_c;

  // Decoded write strobes and status terms
  always_comb begin
    wr_ctrl_c    = avs_write && (avs_address == REG_CTRL);
    start_c      = wr_ctrl_c && avs_writedata[CTRL_START_BIT];
    clear_c      = wr_ctrl_c && avs_writedata[CTRL_CLEAR_BIT];
    wr_b_c       = avs_write && (avs_address == REG_DATA_B);
    busy_c       = (state == ACCUM) || (state == DRAIN);
    done_c       = (state == DONE);
    start_ok_c   = start_c && ((state == IDLE) || (state == DONE));
    drain_exit_c = (state == DRAIN) && !s0_valid;
    sum_c        = {1'b0, acc} + (ACC_W+1)'(s1_cnt);
  end

  hamming_popcount32 u_popcount (
    .data    (32'(s0_xor)),
    .count_c (pop_c)
  );

  // Job FSM, 3-stage datapath and configuration registers; clear overrides all
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_reg   <= '0;
      remaining <= '0;
      a_reg     <= '0;
      acc       <= '0;
      overflow  <= 1'b0;
      s0_valid  <= 1'b0;
      s0_xor    <= '0;
      s1_valid  <= 1'b0;
      s1_cnt    <= '0;
    end else begin
      s0_valid <= 1'b0;
      s1_valid <= s0_valid;
      s1_cnt   <= pop_c;
      if (s1_valid) begin
        if (sum_c[ACC_W]) begin
          acc      <= '1;
          overflow <= 1'b1;
        end else begin
          acc <= sum_c[ACC_W-1:0];
        end
      end
      if (avs_write && (avs_address == REG_LEN)) len_reg <= LEN_W'(avs_writedata);
      if (avs_write && (avs_address == REG_DATA_A)) a_reg <= DATA_W'(avs_writedata);
      case (state)
        IDLE, DONE: begin
          if (start_c) begin
            state     <= (len_reg == '0) ? DRAIN : ACCUM;
            remaining <= len_reg;
            acc       <= '0;
            overflow  <= 1'b0;
          end
        end
        ACCUM: begin
          if (wr_b_c) begin
            s0_valid  <= 1'b1;
            s0_xor    <= a_reg ^ DATA_W'(avs_writedata);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // s1 retires on this edge when s0 is already empty
          if (!s0_valid) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (clear_c) begin
        state     <= IDLE;
        acc       <= '0;
        remaining <= '0;
        overflow  <= 1'b0;
        s0_valid  <= 1'b0;
        s1_valid  <= 1'b0;
      end
    end
  end

`ifdef HAMMING_IRQ_EN
  logic irq_en;

  // Interrupt enable and level interrupt raised on job completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (avs_write && (avs_address == REG_IRQ_EN)) irq_en <= avs_writedata[0];
      if (start_ok_c || clear_c) irq <= 1'b0;
      else if (drain_exit_c && irq_en) irq <= 1'b1;
    end
  end
`endif

  // Read data multiplexer
  always_comb begin
    rd_mux_c = '0;
    case (avs_address)
      REG_STATUS: begin
        rd_mux_c[STAT_BUSY_BIT] = busy_c;
        rd_mux_c[STAT_DONE_BIT] = done_c;
        rd_mux_c[STAT_OVF_BIT]  = overflow;
        rd_mux_c[STAT_REM_LSB +: STAT_REM_W] = STAT_REM_W'(remaining);
      end
      REG_LEN:    rd_mux_c = 32'(len_reg);
      REG_RESULT: rd_mux_c = 32'(acc);
`ifdef HAMMING_IRQ_EN
      REG_IRQ_EN: rd_mux_c[0] = irq_en;
`endif
      default:    rd_mux_c = '0;
    endcase
  end

  // Registered read data and LED status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      led_status   <= '0;
    end else begin
      avs_readdata <= avs_read ? rd_mux_c : '0;
      led_status   <= {overflow, done_c, busy_c};
    end
  end

endmodule

// File: tb/tb_hamming_dist_avs.sv
// Scoreboard bench for hamming_dist_avs: two instances (ACC_W=32 and ACC_W=6)
// share one bus; sel steers strobes and picks which read data is checked.
module tb_hamming_dist_avs;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_LEN    = 3'd2;
  localparam logic [2:0] A_DA     = 3'd3;
  localparam logic [2:0] A_DB     = 3'd4;
  localparam logic [2:0] A_RESULT = 3'd5;
  localparam logic [2:0] A_IRQEN  = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] rdata0, rdata1;
  logic [2:0]  led0, led1;
`ifdef HAMMING_IRQ_EN
  logic        irq0, irq1;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        s;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  hamming_dist_avs #(.DATA_W(32), .ACC_W(32), .LEN_W(16)) u_dut0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read && !sel),
    .avs_write     (avs_write && !sel),
    .avs_writedata (avs_writedata),
    .avs_readdata  (rdata0),
`ifdef HAMMING_IRQ_EN
    .irq           (irq0),
`endif
    .led_status    (led0)
  );

  hamming_dist_avs #(.DATA_W(32), .ACC_W(6), .LEN_W(16)) u_dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read && sel),
    .avs_write     (avs_write && sel),
    .avs_writedata (avs_writedata),
    .avs_readdata  (rdata1),
`ifdef HAMMING_IRQ_EN
    .irq           (irq1),
`endif
    .led_status    (led1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic s, input logic [2:0] a, input logic [31:0] d);
    sel = s; avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic s, input logic [2:0] a, input logic [31:0] exp, input string nm);
    sb.push_back('{s: s, exp: exp, name: nm});
    sel = s; avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  // Monitor: read data is due the cycle after the strobe
  logic rd_q = 1'b0;
  logic rd_sel_q = 1'b0;
  always @(posedge clk) begin
    rd_q     <= avs_read;
    rd_sel_q <= sel;
  end

  always @(negedge clk) begin
    if (rd_q) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=0x%08h expected=no_read", rd_sel_q ? rdata1 : rdata0);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, rd_sel_q ? rdata1 : rdata0, mon_e.exp);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);

    // Reset state
    check("reset_led0", 32'(led0), 32'h0);
    rd(0, A_STATUS, 32'h0, "reset_status");
    rd(0, A_RESULT, 32'h0, "reset_result");
    rd(1, A_RESULT, 32'h0, "reset_result_acc6");

    // Single pair, full distance; result lands 3 cycles after the B write
    wr(0, A_LEN, 32'd1);
    wr(0, A_CTRL, 32'h1);
    wr(0, A_DA, 32'hFFFF_0000);
    wr(0, A_DB, 32'h0000_FFFF);
    rd(0, A_RESULT, 32'd0,  "latency_e1");
    rd(0, A_RESULT, 32'd0,  "latency_e2");
    rd(0, A_RESULT, 32'd32, "latency_e3");
    rd(0, A_STATUS, 32'h0000_0002, "one_pair_status");
    idle(1);
    check("one_pair_led", 32'(led0), 32'h2);

    // Back-to-back B writes: 1+2+3+4
    wr(0, A_LEN, 32'd4);
    wr(0, A_CTRL, 32'h1);
    wr(0, A_DA, 32'h0);
    rd(0, A_STATUS, 32'h0004_0001, "b2b_busy_status");
    wr(0, A_DB, 32'h1);
    wr(0, A_DB, 32'h3);
    wr(0, A_DB, 32'h7);
    wr(0, A_DB, 32'hF);
    idle(4);
    rd(0, A_RESULT, 32'd10, "b2b_result");
    rd(0, A_STATUS, 32'h0000_0002, "b2b_status");

    // Start while ACCUM ignored; LEN write while busy does not touch the job
    wr(0, A_LEN, 32'd2);
    wr(0, A_CTRL, 32'h1);
    wr(0, A_DB, 32'h1);
    wr(0, A_CTRL, 32'h1);
    wr(0, A_LEN, 32'd7);
    rd(0, A_STATUS, 32'h0001_0001, "restart_ignored_status");
    wr(0, A_DB, 32'h1);
    idle(4);
    rd(0, A_RESULT, 32'd2, "restart_ignored_result");
    rd(0, A_STATUS, 32'h0000_0002, "restart_ignored_done");
    rd(0, A_LEN, 32'd7, "len_readback");

    // Zero-length job
    wr(0, A_LEN, 32'd0);
`ifdef HAMMING_IRQ_EN
    wr(0, A_IRQEN, 32'h1);
    wr(0, A_CTRL, 32'h1);
    idle(1);
    check("irq_rise", 32'(irq0), 32'h1);
    rd(0, A_IRQEN, 32'h1, "irq_en_readback");
    wr(0, A_CTRL, 32'h1);
    check("irq_cleared_by_start", 32'(irq0), 32'h0);
`else
    wr(0, A_IRQEN, 32'h1);
    rd(0, A_IRQEN, 32'h0, "irq_en_absent");
    wr(0, A_CTRL, 32'h1);
`endif
    idle(3);
    rd(0, A_STATUS, 32'h0000_0002, "len0_status");
    rd(0, A_RESULT, 32'd0, "len0_result");

    // Clear mid-job with pairs still in the pipeline
    wr(0, A_LEN, 32'd5);
    wr(0, A_CTRL, 32'h1);
    wr(0, A_DB, 32'h1);
    wr(0, A_DB, 32'h3);
    wr(0, A_CTRL, 32'h3);
    rd(0, A_STATUS, 32'h0, "clear_status");
    rd(0, A_RESULT, 32'h0, "clear_result");
    rd(0, A_CTRL, 32'h0, "ctrl_reads_zero");
    wr(0, A_DB, 32'hFF);
    idle(4);
    rd(0, A_RESULT, 32'h0, "idle_b_ignored_result");
    rd(0, A_STATUS, 32'h0, "idle_b_ignored_status");

    // Saturation on the 6-bit accumulator: 32, then 64 -> 63 with overflow
    wr(1, A_LEN, 32'd3);
    wr(1, A_CTRL, 32'h1);
    wr(1, A_DA, 32'h0);
    wr(1, A_DB, 32'hFFFF_FFFF);
    wr(1, A_DB, 32'hFFFF_FFFF);
    wr(1, A_DB, 32'hFFFF_FFFF);
    idle(5);
    rd(1, A_RESULT, 32'd63, "sat_result");
    rd(1, A_STATUS, 32'h0000_0006, "sat_status");
    check("sat_led", 32'(led1), 32'h6);

    // Asynchronous reset mid-job
    wr(0, A_LEN, 32'd3);
    wr(0, A_CTRL, 32'h1);
    wr(0, A_DB, 32'h1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_led", 32'(led0), 32'h0);
    #2 reset_n = 1'b1;
    idle(1);
    rd(0, A_STATUS, 32'h0, "post_reset_status");
    rd(0, A_RESULT, 32'h0, "post_reset_result");
    rd(0, A_LEN, 32'h0, "post_reset_len");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending reads", sb.size());
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
